// File: rtl/lvds_rx_deframer.sv
// Receive deframer: hunts for the A/5 sync word in the recovered nibble stream,
// rebuilds length-prefixed payload bytes, checks the additive checksum and counts frames.
module lvds_rx_deframer #(
    parameter logic [15:0] MAX_LEN     = 16'd4096,
    parameter logic [7:0]  GAP_TIMEOUT = 8'd64
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic [3:0]  din,
    input  logic        din_vld,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic        dout_sof,
    output logic        dout_eof,
    output logic [15:0] dout_len,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [31:0] cnt_frame_ok,
    output logic [31:0] cnt_frame_err
);

    typedef enum logic [2:0] {S_IDLE, S_SYNC2, S_LEN, S_PAY, S_CSUM} state_t;

    state_t      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic [1:0]  nib_q, nib_d;
    logic [11:0] len_sh_q, len_sh_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [3:0]  hi_q, hi_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  dout_q, dout_d;
    logic        vld_q, vld_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [31:0] cnt_ok_q, cnt_ok_d;
    logic [31:0] cnt_err_q, cnt_err_d;
    logic [15:0] len_new;
    logic [7:0]  byte_new;

    always_comb begin
        len_new  = {len_sh_q, din};
        byte_new = {hi_q, din};
        state_d  = state_q;
        nib_d    = nib_q;
        len_sh_d = len_sh_q;
        len_d    = len_q;
        idx_d    = idx_q;
        hi_d     = hi_q;
        sum_d    = sum_q;
        dout_d   = dout_q;
        vld_d    = 1'b0;
        sof_d    = 1'b0;
        eof_d    = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;

        // Idle line time between frames is not a gap.
        if (state_q == S_IDLE || din_vld) gap_d = 8'd0;
        else                              gap_d = gap_q + 8'd1;

        if (din_vld) begin
            unique case (state_q)
                S_IDLE: begin
                    if (din == 4'hA) state_d = S_SYNC2;
                end
                S_SYNC2: begin
                    nib_d = 2'd0;
                    if (din == 4'h5)      state_d = S_LEN;
                    else if (din != 4'hA) state_d = S_IDLE;
                end
                S_LEN: begin
                    len_sh_d = len_new[11:0];
                    nib_d    = nib_q + 2'd1;
                    if (nib_q == 2'd3) begin
                        if (len_new == 16'd0 || len_new > MAX_LEN) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            len_d   = len_new;
                            sum_d   = 8'd0;
                            idx_d   = 16'd0;
                            nib_d   = 2'd0;
                            state_d = S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (nib_q == 2'd0) begin
                        hi_d  = din;
                        nib_d = 2'd1;
                    end else begin
                        nib_d  = 2'd0;
                        dout_d = byte_new;
                        vld_d  = 1'b1;
                        sof_d  = (idx_q == 16'd0);
                        eof_d  = (idx_q == len_q - 16'd1);
                        sum_d  = sum_q + byte_new;
                        idx_d  = idx_q + 16'd1;
                        if (idx_q == len_q - 16'd1) state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (nib_q == 2'd0) begin
                        hi_d  = din;
                        nib_d = 2'd1;
                    end else begin
                        nib_d   = 2'd0;
                        state_d = S_IDLE;
                        if (byte_new == sum_q) ok_d  = 1'b1;
                        else                   err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && gap_d == GAP_TIMEOUT) begin
            // Truncated frame: no eof is issued, frame_err marks the loss.
            err_d   = 1'b1;
            gap_d   = 8'd0;
            state_d = S_IDLE;
        end

        cnt_ok_d  = cnt_ok_q + {31'd0, ok_d};
        cnt_err_d = cnt_err_q + {31'd0, err_d};
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gap_q     <= 8'd0;
            nib_q     <= 2'd0;
            len_sh_q  <= 12'd0;
            len_q     <= 16'd0;
            idx_q     <= 16'd0;
            hi_q      <= 4'd0;
            sum_q     <= 8'd0;
            dout_q    <= 8'd0;
            vld_q     <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt_ok_q  <= 32'd0;
            cnt_err_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            nib_q     <= nib_d;
            len_sh_q  <= len_sh_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            hi_q      <= hi_d;
            sum_q     <= sum_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            cnt_ok_q  <= cnt_ok_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    assign dout          = dout_q;
    assign dout_vld      = vld_q;
    assign dout_sof      = sof_q;
    assign dout_eof      = eof_q;
    assign dout_len      = len_q;
    assign frame_ok      = ok_q;
    assign frame_err     = err_q;
    assign cnt_frame_ok  = cnt_ok_q;
    assign cnt_frame_err = cnt_err_q;

endmodule
